// File: rtl/cpu_program_loader_pkg.sv
// Shared definitions for the CPU serial programming loader:
// FSM encoding, default sizing and CPU pin indices.
package cpu_prog_pkg;

   localparam int unsigned MEM_BYTES_DEFAULT = 16;
   localparam int unsigned TIMEOUT_DEFAULT   = 255;

   localparam int unsigned PROG_PIN  = 0;
   localparam int unsigned READY_PIN = 1;
   localparam int unsigned DONE_PIN  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_SEND,
      ST_WAIT_DONE,
      ST_FINISH
   } state_e;

endpackage

// File: rtl/cpu_program_loader_if.sv
// CPU-side programming pins: the loader is master, the CPU is slave.
interface cpu_program_loader_if;

   logic       prog_mode;
   logic [7:0] prog_data;
   logic       cpu_ready;
   logic       cpu_done_load;

   modport master (
      output prog_mode,
      output prog_data,
      input  cpu_ready,
      input  cpu_done_load
   );

   modport slave (
      input  prog_mode,
      input  prog_data,
      output cpu_ready,
      output cpu_done_load
   );

endinterface

// File: rtl/cpu_program_loader_program_buffer.sv
// Program image store: register file with async clear, sync write, async read.
module program_buffer #(
   parameter int unsigned MEM_BYTES = 16,
   parameter int unsigned AW        = $clog2(MEM_BYTES)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   logic [7:0] mem_q [MEM_BYTES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < MEM_BYTES; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/cpu_program_loader.sv
// Host-side transmitter that streams a buffered program image into the
// CPU over its prog_mode / prog_data / ready / done_load handshake.
module cpu_program_loader
   import cpu_prog_pkg::*;
#(
   parameter int unsigned MEM_BYTES      = MEM_BYTES_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        host_wr_en,
   input  logic [3:0]                  host_wr_addr,
   input  logic [7:0]                  host_wr_data,
   input  logic                        start,
   input  logic [4:0]                  start_len,
   cpu_program_loader_if.master        cpu,
   output logic                        busy,
   output logic                        done,
   output logic                        error,
   output logic [4:0]                  bytes_sent
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   state_e      state_q, state_d;
   logic [4:0]  ptr_q, ptr_d;
   logic [4:0]  len_q, len_d;
   logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
   logic [4:0]  sent_q, sent_d;
   logic        mode_q, mode_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [4:0]  len_clamped;
   logic [7:0]  rd_data;

   program_buffer #(.MEM_BYTES(MEM_BYTES), .AW(4)) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (host_wr_en && (state_q == ST_IDLE)),
      .wr_addr (host_wr_addr),
      .wr_data (host_wr_data),
      .rd_addr (ptr_q[3:0]),
      .rd_data (rd_data)
   );

   assign len_clamped = (start_len > 5'(MEM_BYTES)) ? 5'(MEM_BYTES) : start_len;
   assign tmo_inc     = tmo_q + 1'b1;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      len_d   = len_q;
      tmo_d   = tmo_q;
      sent_d  = sent_q;
      mode_d  = mode_q;
      busy_d  = busy_q;
      done_d  = done_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               done_d = 1'b0;
               err_d  = 1'b0;
               sent_d = '0;
               ptr_d  = '0;
               tmo_d  = '0;
               len_d  = len_clamped;
               if (len_clamped == '0) done_d = 1'b1;
               else                   state_d = ST_ARM;
            end
         end
         ST_ARM: begin
            mode_d  = 1'b1;
            busy_d  = 1'b1;
            state_d = ST_SEND;
         end
         ST_SEND: begin
            // Acceptance takes priority over both timeout and early done_load.
            if (cpu.cpu_ready) begin
               ptr_d  = ptr_q + 5'd1;
               sent_d = sent_q + 5'd1;
               tmo_d  = '0;
               if (ptr_q == len_q - 5'd1) begin
                  if (cpu.cpu_done_load) begin
                     done_d  = 1'b1;
                     state_d = ST_FINISH;
                  end else begin
                     state_d = ST_WAIT_DONE;
                  end
               end else if (cpu.cpu_done_load) begin
                  err_d   = 1'b1;
                  state_d = ST_FINISH;
               end
            end else if (cpu.cpu_done_load) begin
               err_d   = 1'b1;
               state_d = ST_FINISH;
            end else begin
               tmo_d = tmo_inc;
               if (tmo_inc == TW'(TIMEOUT_CYCLES)) begin
                  err_d   = 1'b1;
                  mode_d  = 1'b0;
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_WAIT_DONE: begin
            if (cpu.cpu_done_load) begin
               done_d  = 1'b1;
               state_d = ST_FINISH;
            end else begin
               tmo_d = tmo_inc;
               if (tmo_inc == TW'(TIMEOUT_CYCLES)) begin
                  err_d   = 1'b1;
                  mode_d  = 1'b0;
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_FINISH: begin
            mode_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         len_q   <= '0;
         tmo_q   <= '0;
         sent_q  <= '0;
         mode_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         len_q   <= len_d;
         tmo_q   <= tmo_d;
         sent_q  <= sent_d;
         mode_q  <= mode_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign cpu.prog_mode = mode_q;
   assign cpu.prog_data = (state_q == ST_SEND) ? rd_data : '0;
   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = err_q;
   assign bytes_sent    = sent_q;

endmodule

// File: doc/cpu_program_loader.md
Name: cpu_program_loader

Overview:
Host-side transmitter for the CPU's serial programming interface. It buffers a program image of up to 16 bytes, then drives the CPU's programming pins: prog_mode goes to uio_in[0], prog_data goes to ui_in, and it samples ready_for_ui (uio_out[1]) and done_load (uio_out[2]). It sits on the FPGA/test-harness side of the chip boundary and also serves as the cocotb loader model.

Parameters:
MEM_BYTES, 16, program buffer depth; matches CPU RAM size.
TIMEOUT_CYCLES, 255, maximum idle cycles without cpu_ready before abort.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
host_wr_en  in  1  write host_wr_data into buffer at host_wr_addr
host_wr_addr  in  4  buffer address
host_wr_data  in  8  program byte
start  in  1  one-cycle pulse; begin transfer of start_len bytes
start_len  in  5  bytes to send, 0..16
cpu_ready  in  1  CPU ready_for_ui; CPU captures prog_data on every rising edge where this is high
cpu_done_load  in  1  CPU done_load
prog_mode  out  1  to CPU programming input (uio_in[0])
prog_data  out  8  to CPU ui_in
busy  out  1  transfer in progress
done  out  1  level; last transfer completed cleanly
error  out  1  level; last transfer aborted (timeout or early done_load)
bytes_sent  out  5  bytes accepted by CPU in current/last transfer

Behaviour:
- Reset (asynchronous): state IDLE; ptr, len, timeout counter, bytes_sent = 0; prog_mode, busy, done, error = 0; buffer contents cleared to 0x00.
- Buffer writes are honoured only in IDLE and DONE/ERROR. Writes while busy are ignored. A write takes effect on the next edge.
- start_len > MEM_BYTES is clamped to MEM_BYTES. A start while busy is ignored.
- State machine with states IDLE, ARM, SEND, WAIT_DONE, FINISH:
  - IDLE: on start, clear done, error, bytes_sent and ptr, then latch len.
    - len = 0: set done immediately and stay in IDLE. prog_mode is never asserted.
    - Otherwise go to ARM.
  - ARM (1 cycle): prog_mode <= 1, busy = 1, go to SEND.
  - SEND:
    - prog_data = buffer[ptr] (combinational read of registered ptr). prog_data = 0x00 in all other states.
    - On an edge with cpu_ready = 1: ptr++, bytes_sent++, timeout counter cleared.
    - If that accepted byte is ptr == len-1, go to WAIT_DONE.
  - WAIT_DONE: hold prog_data = 0x00 and prog_mode = 1. On cpu_done_load = 1, go to FINISH with done <= 1.
  - FINISH (1 cycle): prog_mode <= 0, busy <= 0, return to IDLE. done and error hold until the next start.
- Timeout:
  - In SEND and WAIT_DONE, the counter increments on every cycle without progress.
  - On reaching TIMEOUT_CYCLES: error <= 1, prog_mode <= 0, busy <= 0, go to IDLE.
- Early done: cpu_done_load = 1 while in SEND sets error <= 1 and goes to FINISH. bytes_sent retains the count actually accepted.
- Simultaneous events in SEND:
  - cpu_ready and cpu_done_load together: the byte counts as accepted, then the early-done rule is applied unless it was the last byte (then done).
  - cpu_ready and timeout expiry on the same edge: acceptance wins.
- Reset mid-transfer forces prog_mode low immediately (asynchronous). The CPU sees programming deasserted.
- Latency: prog_mode rises 2 edges after start. Each byte costs at least 1 cycle. prog_mode falls 2 edges after the done_load edge.

Decomposition:
- Shared package cpu_prog_pkg holds:
  - the state encoding (IDLE, ARM, SEND, WAIT_DONE, FINISH);
  - MEM_BYTES_DEFAULT and TIMEOUT_DEFAULT;
  - the CPU pin-index constants PROG_PIN = 0, READY_PIN = 1 and DONE_PIN = 2.
- One sub-module: program_buffer, a MEM_BYTES x 8 register file with async-clear, a sync write port and an async read port.
- The FSM and counters stay in the top.

Test Plan:
1. Load 0x1E,0x2F,0xE0,0xF0 at addresses 0..3, start_len=4, cpu_ready held high, cpu_done_load pulsed one cycle after the 4th byte -> CPU sees 0x1E,0x2F,0xE0,0xF0 on consecutive edges; bytes_sent=4, done=1, error=0, prog_mode low 2 cycles later.
2. Same image with cpu_ready toggling 1-0-1-0 -> bytes advance only on ready edges, sequence unchanged, done=1.
3. start_len=3, cpu_ready never asserted -> after 255 cycles error=1, prog_mode=0, bytes_sent=0, busy=0.
4. start_len=4, cpu_done_load asserted after 2 bytes accepted -> error=1, done=0, bytes_sent=2.
5. start_len=0 -> done=1 next cycle, prog_mode never rises. start_len=20 -> exactly 16 bytes sent.
6. rst_n pulled low in SEND after byte 1 -> prog_mode, busy and bytes_sent 0 immediately, buffer reads 0x00. A host write during busy has no effect on the transmitted data.
